// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C write master.
package i2c_pkg;

    localparam int   I2C_ADDR_W = 7;
    localparam logic RW_WRITE   = 1'b0;

    // Number of SCL quarter-periods spent in each kind of phase
    localparam int START_Q = 2;
    localparam int BIT_Q   = 4;
    localparam int STOP_Q  = 3;

    typedef enum logic [2:0] {
        IDLE,
        START,
        ADDR,
        ADDR_ACK,
        DATA,
        DATA_ACK,
        STOP
    } state_t;

    // First byte on the wire: 7-bit address followed by the R/W bit
    function automatic logic [7:0] addr_byte(input logic [I2C_ADDR_W-1:0] addr);
        return {addr, RW_WRITE};
    endfunction

endpackage

// File: rtl/i2c_master_write_if.sv
// Request/status handshake plus the open-drain line controls of the write master.
interface i2c_master_write_if;
    import i2c_pkg::*;

    logic                  start;
    logic [I2C_ADDR_W-1:0] addr;
    logic [7:0]            data;
    logic                  busy;
    logic                  done;
    logic                  ack_error;
    logic                  scl_oe;
    logic                  sda_oe;
    logic                  sda_in;

    // View of the I2C master itself
    modport master (
        input  start, addr, data, sda_in,
        output busy, done, ack_error, scl_oe, sda_oe
    );

    // View of whatever issues requests and models the bus
    modport slave (
        output start, addr, data, sda_in,
        input  busy, done, ack_error, scl_oe, sda_oe
    );

endinterface

// File: rtl/i2c_quarter_tick.sv
// Divider producing one tick every CLK_DIV clocks; SCL quarter-period timebase.
module i2c_quarter_tick #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic clr,
    input  logic en,
    output logic tick
);
    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] r_count;
    logic          w_last;

    assign w_last = (r_count == CW'(CLK_DIV - 1));
    assign tick   = en & w_last;

    // Count 0..CLK_DIV-1 while enabled; parked at zero otherwise so the
    // first quarter after acceptance is always a full CLK_DIV long
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_count <= '0;
        end else if (!en || w_last) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/i2c_master_write.sv
// I2C master issuing single-byte write frames: START, addr+W, ACK, data, ACK, STOP.
module i2c_master_write
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic               clk,
    input  logic               clr,
    i2c_master_write_if.master bus
);
    state_t     r_state,     w_state_next;
    logic [1:0] r_quarter,   w_quarter_next;
    logic [2:0] r_bit_cnt,   w_bit_cnt_next;
    logic [7:0] r_shift,     w_shift_next;
    logic [7:0] r_data,      w_data_next;
    logic       r_ack_error, w_ack_error_next;
    logic       r_done,      w_done_next;
    logic       r_scl_oe,    w_scl_oe_next;
    logic       r_sda_oe,    w_sda_oe_next;
    logic       w_tick;
    logic       w_en;

    assign w_en = (r_state != IDLE);

    i2c_quarter_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk  (clk),
        .clr  (clr),
        .en   (w_en),
        .tick (w_tick)
    );

    assign bus.busy      = (r_state != IDLE);
    assign bus.done      = r_done;
    assign bus.ack_error = r_ack_error;
    assign bus.scl_oe    = r_scl_oe;
    assign bus.sda_oe    = r_sda_oe;

    // State, datapath and registered line drivers
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state     <= IDLE;
            r_quarter   <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_data      <= '0;
            r_ack_error <= 1'b0;
            r_done      <= 1'b0;
            r_scl_oe    <= 1'b0;
            r_sda_oe    <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_quarter   <= w_quarter_next;
            r_bit_cnt   <= w_bit_cnt_next;
            r_shift     <= w_shift_next;
            r_data      <= w_data_next;
            r_ack_error <= w_ack_error_next;
            r_done      <= w_done_next;
            r_scl_oe    <= w_scl_oe_next;
            r_sda_oe    <= w_sda_oe_next;
        end
    end

    // Next-state: phases advance one quarter per tick; r_ack_error doubles as
    // the address-ACK verdict because it is cleared on acceptance
    always_comb begin
        w_state_next     = r_state;
        w_quarter_next   = r_quarter;
        w_bit_cnt_next   = r_bit_cnt;
        w_shift_next     = r_shift;
        w_data_next      = r_data;
        w_ack_error_next = r_ack_error;
        w_done_next      = 1'b0;

        case (r_state)
            IDLE: begin
                // The done cycle still counts as busy, so a request there waits
                if (bus.start && !r_done) begin
                    w_state_next     = START;
                    w_quarter_next   = '0;
                    w_bit_cnt_next   = '0;
                    w_shift_next     = addr_byte(bus.addr);
                    w_data_next      = bus.data;
                    w_ack_error_next = 1'b0;
                end
            end

            START: begin
                if (w_tick) begin
                    if (r_quarter == 2'(START_Q - 1)) begin
                        w_state_next   = ADDR;
                        w_quarter_next = '0;
                    end else begin
                        w_quarter_next = r_quarter + 1'b1;
                    end
                end
            end

            ADDR, DATA: begin
                if (w_tick) begin
                    if (r_quarter == 2'(BIT_Q - 1)) begin
                        w_quarter_next = '0;
                        w_shift_next   = {r_shift[6:0], 1'b0};
                        w_bit_cnt_next = r_bit_cnt + 1'b1;
                        if (r_bit_cnt == 3'd7) begin
                            w_state_next = (r_state == ADDR) ? ADDR_ACK : DATA_ACK;
                        end
                    end else begin
                        w_quarter_next = r_quarter + 1'b1;
                    end
                end
            end

            ADDR_ACK, DATA_ACK: begin
                if (w_tick) begin
                    // Sample at the end of the SCL-high first half
                    if (r_quarter == 2'd2 && bus.sda_in) begin
                        w_ack_error_next = 1'b1;
                    end
                    if (r_quarter == 2'(BIT_Q - 1)) begin
                        w_quarter_next = '0;
                        if (r_state == DATA_ACK || r_ack_error) begin
                            w_state_next = STOP;
                        end else begin
                            w_state_next = DATA;
                            w_shift_next = r_data;
                        end
                    end else begin
                        w_quarter_next = r_quarter + 1'b1;
                    end
                end
            end

            STOP: begin
                if (w_tick) begin
                    if (r_quarter == 2'(STOP_Q - 1)) begin
                        w_state_next   = IDLE;
                        w_quarter_next = '0;
                        w_done_next    = 1'b1;
                    end else begin
                        w_quarter_next = r_quarter + 1'b1;
                    end
                end
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Line decode from the upcoming phase/quarter so SCL/SDA move only on ticks
    always_comb begin
        w_scl_oe_next = 1'b0;
        w_sda_oe_next = 1'b0;
        case (w_state_next)
            START: begin
                w_sda_oe_next = (w_quarter_next == 2'd1);
            end
            ADDR, DATA: begin
                w_scl_oe_next = (w_quarter_next < 2'd2);
                w_sda_oe_next = ~w_shift_next[7];
            end
            ADDR_ACK, DATA_ACK: begin
                w_scl_oe_next = (w_quarter_next < 2'd2);
            end
            STOP: begin
                w_scl_oe_next = (w_quarter_next == 2'd0);
                w_sda_oe_next = (w_quarter_next != 2'd2);
            end
            default: begin
                w_scl_oe_next = 1'b0;
                w_sda_oe_next = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/i2c_master_write.md
Name: i2c_master_write

Overview:
Single-clock I2C controller that generates write transactions for the downstream I2C responder: START, 7-bit address + W bit, ACK check, one data byte, ACK check, STOP. It is the upstream stage that drives the responder's SCL/SDA lines. SCL and SDA are open-drain, so the block only pulls lines low or releases them. No clock stretching and no multi-master arbitration.

Parameters:
CLK_DIV, 4, clk cycles per SCL quarter-period (legal range 2..65535); SCL period = 4*CLK_DIV clk cycles.

Ports:
clk  input  1  system clock, rising edge
clr  input  1  asynchronous active-high reset
start  input  1  request a transaction; accepted when busy=0
addr  input  7  target address; latched on acceptance
data  input  8  byte to write; latched on acceptance
busy  output  1  high from the cycle after acceptance until the done cycle
done  output  1  one-cycle pulse at transaction end
ack_error  output  1  set if the address ACK or the data ACK was a NACK
scl_oe  output  1  1 = pull SCL low, 0 = release (pulled high externally)
sda_oe  output  1  1 = pull SDA low, 0 = release
sda_in  input  1  sampled SDA line level

Behaviour:
- Reset (async, any time, including mid-frame): state IDLE; scl_oe=0, sda_oe=0, busy=0, done=0, ack_error=0; divider and bit counter cleared.
- Quarter tick: the divider counts 0..CLK_DIV-1. The tick fires on count CLK_DIV-1. The divider is held at 0 in IDLE. All line changes occur only on ticks.
- Acceptance: on a clk edge with start=1 and busy=0 (IDLE): latch shift byte = {addr,1'b0} and data; clear ack_error; enter START. start while busy is ignored.
- START (2 quarters): Q0 SCL released, SDA released; Q1 SCL released, SDA low.
- Bit phase (ADDR, DATA), 4 quarters per bit, MSB first:
  - Q0: SCL low, drive SDA = bit.
  - Q1: SCL low.
  - Q2: SCL released.
  - Q3: SCL released.
  - SDA changes only while SCL is low.
- ACK phase (ADDR_ACK, DATA_ACK), 4 quarters: SDA released throughout, SCL same as a bit phase. sda_in is sampled on the tick ending Q2. 0 = ACK; 1 = NACK, which sets ack_error.
- Transitions: IDLE→START→ADDR(8 bits)→ADDR_ACK→DATA(8 bits)→DATA_ACK→STOP→IDLE. A NACK in ADDR_ACK goes directly to STOP (data is skipped).
- STOP (3 quarters): Q0 SCL low, SDA low; Q1 SCL released, SDA low; Q2 SCL released, SDA released.
- done pulses on the clk cycle when the final STOP quarter ends. busy drops in that same cycle. ack_error holds its value until the next acceptance.
- Latency from acceptance edge to done: 77*CLK_DIV clk cycles on full ACK, 41*CLK_DIV on address NACK.
- Bit counter is 3 bits and wraps 7→0 on the last bit of each byte.
- start asserted in the done cycle: not accepted (busy is still considered 1 in that cycle). It is accepted on the next cycle if still high.

Decomposition:
- Shared package i2c_pkg:
  - state enum (IDLE, START, ADDR, ADDR_ACK, DATA, DATA_ACK, STOP)
  - I2C_ADDR_W=7
  - RW_WRITE=1'b0
  - quarter-count constants START_Q=2, BIT_Q=4, STOP_Q=3
- One sub-module: i2c_quarter_tick (parameter CLK_DIV; inputs clk, clr, en; output tick).
- FSM, shift register and bit counter stay in i2c_master_write.

Test Plan:
- Reset: assert clr mid-idle and at time 0 → scl_oe=0, sda_oe=0, busy=0, done=0, ack_error=0.
- Write with ACKing bus model, CLK_DIV=4, addr=0x33, data=0xA5 → START seen; SDA bits sampled at SCL rise = 0x66 then 0xA5; STOP seen; done at 308 clocks after acceptance; ack_error=0.
- Model NACKs the address (addr=0x12) → bits 0x24 sent, no data bits on the bus, STOP, done at 164 clocks, ack_error=1 and held until the next start.
- Model ACKs the address, NACKs the data → full 0x66 and 0xA5 frames sent, done at 308 clocks, ack_error=1.
- start pulsed and addr/data changed mid-frame → ignored; frame uses the latched values; a second transaction is accepted only after done.
- clr asserted during DATA bit 3 → scl_oe=0 and sda_oe=0 asynchronously, busy=0, no done pulse; a following start yields a correct full frame.
